// File: rtl/key_conditioner_pkg.sv
// Shared types for the push-button conditioner.
// State encodings match the values the display/debug logic already decodes.
package key_conditioner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_PRESSED     = 3'd2,
        ST_HELD        = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } key_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous board input.
// RST_VAL is the value both stages take while rst is high.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounces one active-low push-button and derives level, edge pulses,
// long-press flag and an auto-repeat pulse train, all registered.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 8_333_333,
    parameter int unsigned CNT_W           = 28
) (
    input  logic clock,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic key_n_s2;

    key_state_e       state_q, state_d;
    key_state_e       ret_q, ret_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;

    logic pressed_q, pressed_d;
    logic press_pulse_q, press_pulse_d;
    logic release_pulse_q, release_pulse_d;
    logic long_press_q, long_press_d;
    logic repeat_pulse_q, repeat_pulse_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clock (clock),
        .rst   (rst),
        .d     (key_n),
        .q     (key_n_s2)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] last);
        sat_inc = (v == last) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            ret_q           <= ST_IDLE;
            cnt_q           <= '0;
            rcnt_q          <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_press_q    <= 1'b0;
            repeat_pulse_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            ret_q           <= ret_d;
            cnt_q           <= cnt_d;
            rcnt_q          <= rcnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_press_q    <= long_press_d;
            repeat_pulse_q  <= repeat_pulse_d;
        end
    end

    // The cycle that detects a release still counts toward the hold/repeat
    // interval, so a glitch delays the cadence by exactly its dwell.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!key_n_s2) state_d = ST_DEB_PRESS;
            end
            ST_DEB_PRESS: begin
                if (key_n_s2) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (key_n_s2) begin
                    state_d = ST_DEB_RELEASE;
                    ret_d   = ST_PRESSED;
                    rcnt_d  = '0;
                    cnt_d   = sat_inc(cnt_q, HOLD_LAST);
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (key_n_s2) begin
                    state_d = ST_DEB_RELEASE;
                    ret_d   = ST_HELD;
                    rcnt_d  = '0;
                    cnt_d   = sat_inc(cnt_q, REP_LAST);
                end else if (cnt_q == REP_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DEB_RELEASE: begin
                if (!key_n_s2) begin
                    state_d = ret_q;
                end else if (rcnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                rcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        pressed_d       = (state_d == ST_PRESSED) || (state_d == ST_HELD) ||
                          (state_d == ST_DEB_RELEASE);
        long_press_d    = (state_d == ST_HELD) ||
                          ((state_d == ST_DEB_RELEASE) && (ret_d == ST_HELD));
        press_pulse_d   = (state_q == ST_DEB_PRESS) && (state_d == ST_PRESSED);
        release_pulse_d = (state_q == ST_DEB_RELEASE) && (state_d == ST_IDLE);
        repeat_pulse_d  = ((state_q == ST_PRESSED) && (state_d == ST_HELD)) ||
                          ((state_q == ST_HELD) && (state_d == ST_HELD) &&
                           (cnt_q == REP_LAST));
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_press    = long_press_q;
    assign repeat_pulse  = repeat_pulse_q;

endmodule
